column_serial_ctrl: RTL and testbench
=====================================

// Module: column_serial_ctrl
// PURPOSE
//  Sequencer/flow controller in front of one column_serial buffer (1-port-write, 1-port-read RAM, free-running wrap pointers).
//  Tracks occupancy, back-pressures the writer so the buffer never overflows, and on command streams one column
//  (col_len words) out of the buffer as a valid/last burst. Sits between the activation fetch path and the PE column feed.
// PARAMETERS
//  DATA_WIDTH  8  word width, equal to the attached column_serial
//  ADDR_WIDTH  6  buffer address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  clk          in   1             clock
//  reset        in   1             reset, synchronous, active-high; same reset drives the attached column_serial
//  s_valid      in   1             write-side word valid
//  s_ready      out  1             write-side ready (= !full)
//  s_data       in   DATA_WIDTH    write-side word
//  rd_start     in   1             pulse: read one column of col_len words
//  col_len      in   ADDR_WIDTH+1  column length, sampled on accepted rd_start, 1..DEPTH
//  busy         out  1             FSM not in IDLE
//  m_valid      out  1             output word valid (no back-pressure)
//  m_data       out  DATA_WIDTH    output word (= buf_rd_data)
//  m_last       out  1             final word of column, qualified by m_valid
//  rd_done      out  1             one-cycle pulse, same cycle as m_last (or zero-length completion)
//  occupancy    out  ADDR_WIDTH+1  words held, 0..DEPTH
//  full         out  1             occupancy == DEPTH
//  empty        out  1             occupancy == 0
//  cfg_err      out  1             sticky: rd_start with col_len > DEPTH
//  buf_wr_req   out  1             to column_serial wr_req_p
//  buf_wr_data  out  DATA_WIDTH    to column_serial wr_data_p
//  buf_rd_req   out  1             to column_serial rd_req_p
//  buf_rd_data  in   DATA_WIDTH    from column_serial rd_data_p; valid 1 cycle after buf_rd_req
// BEHAVIOUR
//  Reset: FSM=IDLE; occupancy=0; s_ready=1, empty=1; all other outputs 0; cfg_err cleared.
//  Write: buf_wr_req = s_valid & s_ready (combinational), buf_wr_data = s_data. Never asserted when full.
//  Occupancy: +1 on buf_wr_req only, -1 on buf_rd_req only, unchanged when both or neither. Registered.
//  FSM states IDLE, WAIT, BURST:
//   IDLE: rd_start & col_len==0 -> rd_done pulse next cycle, stay IDLE, no reads.
//         rd_start & col_len>DEPTH -> set cfg_err, ignore, stay IDLE.
//         rd_start & valid col_len -> latch len, remain=len, go WAIT.
//   WAIT: occupancy >= len -> go BURST. Writes continue.
//   BURST: buf_rd_req=1 every cycle; remain-- each cycle; remain==1 -> IDLE (len consecutive read cycles).
//  rd_start outside IDLE is ignored (no queueing, no error).
//  Output: m_valid = buf_rd_req delayed 1 cycle; m_last = (remain==1 in BURST) delayed 1 cycle; rd_done = m_last.
//  Latency: rd_start with data already present -> first m_valid 3 cycles later (IDLE->WAIT->BURST->data).
//  Wrap: pointers live in column_serial and wrap mod DEPTH; controller guarantees no overflow/underflow, so wrap is safe.
//  Simultaneous write+read at full: not possible (s_ready=0 while full); at DEPTH-1 with read, write accepted, occupancy holds.
//  Reset mid-burst: FSM IDLE immediately, pending m_valid/m_last dropped, occupancy 0; buffer contents discarded.
// TESTING
//  1 Write 10 words 0x01..0x0A, rd_start col_len=10 -> m_data 0x01..0x0A on 10 consecutive m_valid, m_last+rd_done on 0x0A, occupancy 0.
//  2 Write 64 words with s_valid held -> full=1, s_ready=0 at word 64; 65th word not accepted; occupancy=64.
//  3 rd_start col_len=8 with empty buffer -> busy, no m_valid; write 8 words one per 3 cycles -> burst begins after 8th write, data in order.
//  4 Fill 60, read 40, write 40 more (pointer wrap) -> read 60 returns exact write order, no loss/duplication.
//  5 rd_start col_len=0 -> rd_done one cycle later, no m_valid; col_len=65 -> cfg_err=1, no burst, busy stays 0.
//  6 Assert reset at 4th word of a 16-word burst -> next cycle m_valid=0, busy=0, occupancy=0, empty=1, s_ready=1.

Source files
------------

// File: rtl/column_serial_ctrl.sv
// column_serial_ctrl: occupancy tracking, writer back-pressure and column burst sequencing
// for one attached column_serial buffer (1W/1R RAM with free-running wrap pointers).
module column_serial_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   // write side
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   // column read command
   input  logic                  rd_start,
   input  logic [ADDR_WIDTH:0]   col_len,
   output logic                  busy,
   // column output stream
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  rd_done,
   // status
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic                  full,
   output logic                  empty,
   output logic                  cfg_err,
   // buffer interface
   output logic                  buf_wr_req,
   output logic [DATA_WIDTH-1:0] buf_wr_data,
   output logic                  buf_rd_req,
   input  logic [DATA_WIDTH-1:0] buf_rd_data
);

   localparam int unsigned CntW = ADDR_WIDTH + 1;
   localparam logic [CntW-1:0] Depth = CntW'(2 ** ADDR_WIDTH);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StBurst
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] occ_q, occ_d;
   logic [CntW-1:0] len_q, len_d;
   logic [CntW-1:0] remain_q, remain_d;
   logic            cfg_err_q, cfg_err_d;
   logic            m_valid_q, m_valid_d;
   logic            m_last_q, m_last_d;
   logic            zero_done_q, zero_done_d;

   logic start_idle;
   logic len_zero;
   logic len_bad;
   logic start_ok;
   logic last_word;

   // Command decode: rd_start is only looked at in IDLE, anything else is dropped silently.
   always_comb begin
      start_idle = rd_start & (state_q == StIdle);
      len_zero   = (col_len == '0);
      len_bad    = (col_len > Depth);
      start_ok   = start_idle & ~len_zero & ~len_bad;
   end

   // Write path: the writer is only accepted while the buffer has room.
   always_comb begin
      full        = (occ_q == Depth);
      empty       = (occ_q == '0);
      s_ready     = ~full;
      buf_wr_req  = s_valid & s_ready;
      buf_wr_data = s_data;
      occupancy   = occ_q;
   end

   // Occupancy next state: a simultaneous write and read leaves the count unchanged.
   always_comb begin
      occ_d = occ_q;
      case ({buf_wr_req, buf_rd_req})
         2'b10:   occ_d = occ_q + CntW'(1);
         2'b01:   occ_d = occ_q - CntW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: WAIT holds until the whole column is present, so BURST never underflows.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (occ_q >= len_q) begin
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (remain_q == CntW'(1)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: one buffer read per BURST cycle.
   always_comb begin
      busy       = (state_q != StIdle);
      buf_rd_req = (state_q == StBurst);
      last_word  = (state_q == StBurst) && (remain_q == CntW'(1));
   end

   // Datapath next state: length latch, burst countdown, sticky config error, output pipeline.
   always_comb begin
      len_d       = len_q;
      remain_d    = remain_q;
      cfg_err_d   = cfg_err_q;
      if (start_ok) begin
         len_d    = col_len;
         remain_d = col_len;
      end else if (buf_rd_req) begin
         remain_d = remain_q - CntW'(1);
      end
      if (start_idle && len_bad) begin
         cfg_err_d = 1'b1;
      end
      // Read data returns one cycle after the request, so valid/last are delayed to match.
      m_valid_d   = buf_rd_req;
      m_last_d    = last_word;
      zero_done_d = start_idle & len_zero;
   end

   // Datapath registers; reset drops any in-flight output word.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q       <= '0;
         len_q       <= '0;
         remain_q    <= '0;
         cfg_err_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         occ_q       <= occ_d;
         len_q       <= len_d;
         remain_q    <= remain_d;
         cfg_err_q   <= cfg_err_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         zero_done_q <= zero_done_d;
      end
   end

   // Output stream; a zero-length command completes with rd_done alone.
   always_comb begin
      m_valid = m_valid_q;
      m_last  = m_last_q;
      m_data  = buf_rd_data;
      rd_done = m_last_q | zero_done_q;
      cfg_err = cfg_err_q;
   end

endmodule

// File: tb/tb_column_serial_ctrl.sv
// Bench for column_serial_ctrl: behavioural column_serial buffer, in-order word model,
// table-driven command vectors, hand-written corner sequences and a randomized run.
module tb_column_serial_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          rd_start;
   logic [AW:0]   col_len;
   logic          busy;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          rd_done;
   logic [AW:0]   occupancy;
   logic          full;
   logic          empty;
   logic          cfg_err;
   logic          buf_wr_req;
   logic [DW-1:0] buf_wr_data;
   logic          buf_rd_req;
   logic [DW-1:0] buf_rd_data;

   always #5 clk = ~clk;

   column_serial_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .rd_start   (rd_start),
      .col_len    (col_len),
      .busy       (busy),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .rd_done    (rd_done),
      .occupancy  (occupancy),
      .full       (full),
      .empty      (empty),
      .cfg_err    (cfg_err),
      .buf_wr_req (buf_wr_req),
      .buf_wr_data(buf_wr_data),
      .buf_rd_req (buf_rd_req),
      .buf_rd_data(buf_rd_data)
   );

   // Attached column_serial: wrap pointers, read data one cycle after request.
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   always @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (buf_wr_req) begin
            mem[wr_ptr] <= buf_wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (buf_rd_req) begin
            buf_rd_data <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1'b1;
         end
      end
   end

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            done_cnt = 0;
   int            burst_cnt = 0;
   int            last_wr_cyc = 0;
   logic [DW-1:0] exp_q[$];   // words accepted and not yet streamed out, in write order
   logic [DW-1:0] got_q[$];
   int            vcyc_q[$];
   int            burst_q[$];
   int            lens_q[$];

   typedef struct {
      int prefill;
      int len;
      int exp_err;
      int exp_words;
      int exp_done;
      int exp_busy;
   } vec_t;
   vec_t vecs[8];

   function automatic void check(string name, int actual, int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (m_valid) begin
         got_q.push_back(m_data);
         vcyc_q.push_back(cyc);
         burst_cnt++;
         if (m_last) begin
            burst_q.push_back(burst_cnt);
            burst_cnt = 0;
         end
      end
      if (rd_done) done_cnt++;
   endtask

   task automatic clear_book();
      exp_q.delete();
      got_q.delete();
      vcyc_q.delete();
      burst_q.delete();
      lens_q.delete();
      done_cnt  = 0;
      burst_cnt = 0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      rd_start = 1'b0;
      col_len  = '0;
      tick();
      tick();
      reset = 1'b0;
      clear_book();
   endtask

   task automatic push_word(int v);
      s_valid = 1'b1;
      s_data  = DW'(v);
      if (s_ready) begin
         exp_q.push_back(DW'(v));
         last_wr_cyc = cyc + 1;
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic push_words(int n, int base, int gap);
      for (int i = 0; i < n; i++) begin
         push_word(base + i);
         repeat (gap) tick();
      end
   endtask

   task automatic start_read(int len);
      rd_start = 1'b1;
      col_len  = (AW+1)'(len);
      tick();
      rd_start = 1'b0;
      col_len  = '0;
   endtask

   task automatic wait_idle(string name, int budget);
      int k = 0;
      while ((busy || m_valid) && k < budget) begin
         tick();
         k++;
      end
      check({name, " idle within budget"}, int'(busy | m_valid), 0);
   endtask

   task automatic cmp_stream(string name, int n);
      check({name, " word count"}, got_q.size(), n);
      while (got_q.size() > 0) begin
         if (exp_q.size() == 0) begin
            check({name, " extra word"}, 1, 0);
            got_q.delete();
         end else begin
            check({name, " data"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{prefill: 10, len: 10,  exp_err: 0, exp_words: 10, exp_done: 1, exp_busy: 1};
      vecs[1] = '{prefill: 0,  len: 0,   exp_err: 0, exp_words: 0,  exp_done: 1, exp_busy: 0};
      vecs[2] = '{prefill: 0,  len: 65,  exp_err: 1, exp_words: 0,  exp_done: 0, exp_busy: 0};
      vecs[3] = '{prefill: 5,  len: 3,   exp_err: 0, exp_words: 3,  exp_done: 1, exp_busy: 1};
      vecs[4] = '{prefill: 64, len: 64,  exp_err: 0, exp_words: 64, exp_done: 1, exp_busy: 1};
      vecs[5] = '{prefill: 20, len: 1,   exp_err: 0, exp_words: 1,  exp_done: 1, exp_busy: 1};
      vecs[6] = '{prefill: 7,  len: 127, exp_err: 1, exp_words: 0,  exp_done: 0, exp_busy: 0};
      vecs[7] = '{prefill: 3,  len: 0,   exp_err: 0, exp_words: 0,  exp_done: 1, exp_busy: 0};

      do_reset();
      check("reset busy", int'(busy), 0);
      check("reset m_valid", int'(m_valid), 0);
      check("reset occupancy", int'(occupancy), 0);
      check("reset empty", int'(empty), 1);
      check("reset s_ready", int'(s_ready), 1);
      check("reset cfg_err", int'(cfg_err), 0);
      check("reset rd_done", int'(rd_done), 0);

      // Table-driven single commands.
      for (int t = 0; t < 8; t++) begin
         int t0;
         do_reset();
         push_words(vecs[t].prefill, 1, 0);
         t0 = cyc;
         start_read(vecs[t].len);
         check($sformatf("vec%0d busy after start", t), int'(busy), vecs[t].exp_busy);
         check($sformatf("vec%0d cfg_err", t), int'(cfg_err), vecs[t].exp_err);
         wait_idle($sformatf("vec%0d", t), 300);
         repeat (2) tick();
         check($sformatf("vec%0d rd_done count", t), done_cnt, vecs[t].exp_done);
         check($sformatf("vec%0d occupancy", t), int'(occupancy),
               vecs[t].prefill - vecs[t].exp_words);
         if (vcyc_q.size() > 0) begin
            check($sformatf("vec%0d first word latency", t), vcyc_q[0] - t0, 3);
            check($sformatf("vec%0d back-to-back words", t),
                  vcyc_q[vcyc_q.size()-1] - vcyc_q[0], vecs[t].exp_words - 1);
         end
         if (burst_q.size() > 0) begin
            check($sformatf("vec%0d m_last position", t), burst_q[0], vecs[t].exp_words);
         end
         cmp_stream($sformatf("vec%0d", t), vecs[t].exp_words);
      end

      // Fill to capacity with s_valid held: the 65th word must bounce.
      do_reset();
      for (int i = 0; i < 65; i++) begin
         push_word(i + 1);
         if (i == 63) begin
            check("fill full at word 64", int'(full), 1);
            check("fill s_ready at word 64", int'(s_ready), 0);
         end
      end
      check("fill accepted words", exp_q.size(), 64);
      check("fill occupancy", int'(occupancy), 64);
      check("fill buf_wr_req while full", int'(buf_wr_req), 0);
      start_read(64);
      wait_idle("fill drain", 200);
      cmp_stream("fill drain", 64);
      check("fill drain empty", int'(empty), 1);

      // Command on an empty buffer waits for the whole column to arrive.
      do_reset();
      start_read(8);
      check("starve busy", int'(busy), 1);
      repeat (5) tick();
      check("starve no output", got_q.size(), 0);
      push_words(8, 8'h40, 2);
      wait_idle("starve", 100);
      if (vcyc_q.size() > 0) begin
         check("starve burst start after 8th write", vcyc_q[0] - last_wr_cyc, 2);
      end
      cmp_stream("starve", 8);

      // Pointer wrap: 60 in, 40 out, 40 in, 60 out.
      do_reset();
      for (int i = 0; i < 60; i++) push_word(int'($urandom_range(0, 255)));
      start_read(40);
      wait_idle("wrap read40", 200);
      for (int i = 0; i < 40; i++) push_word(int'($urandom_range(0, 255)));
      check("wrap occupancy before read60", int'(occupancy), 60);
      start_read(60);
      wait_idle("wrap read60", 200);
      cmp_stream("wrap", 100);
      check("wrap final occupancy", int'(occupancy), 0);

      // Reset on the 4th word of a 16-word burst.
      do_reset();
      push_words(16, 8'h80, 0);
      start_read(16);
      for (int k = 0; k < 50 && got_q.size() < 4; k++) tick();
      check("midburst reached 4th word", got_q.size(), 4);
      reset = 1'b1;
      tick();
      check("midburst m_valid", int'(m_valid), 0);
      check("midburst busy", int'(busy), 0);
      check("midburst occupancy", int'(occupancy), 0);
      check("midburst empty", int'(empty), 1);
      check("midburst s_ready", int'(s_ready), 1);
      reset = 1'b0;
      clear_book();
      push_words(3, 8'hc0, 0);
      start_read(3);
      wait_idle("after reset", 50);
      cmp_stream("after reset", 3);

      // Randomized traffic against the in-order word model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         s_valid  = ($urandom_range(0, 9) < 6);
         s_data   = DW'($urandom);
         if (s_valid && s_ready) exp_q.push_back(s_data);
         rd_start = 1'b0;
         if (c < 3500 && !busy && $urandom_range(0, 15) == 0) begin
            int len = int'($urandom_range(1, DEPTH));
            rd_start = 1'b1;
            col_len  = (AW+1)'(len);
            lens_q.push_back(len);
         end
         tick();
         if (c >= 3500 && !busy && !m_valid) break;
      end
      s_valid  = 1'b0;
      rd_start = 1'b0;
      wait_idle("random", 200);
      check("random occupancy", int'(occupancy), exp_q.size() - got_q.size());
      check("random burst count", burst_q.size(), lens_q.size());
      check("random rd_done count", done_cnt, lens_q.size());
      for (int i = 0; i < burst_q.size() && i < lens_q.size(); i++) begin
         check($sformatf("random burst %0d length", i), burst_q[i], lens_q[i]);
      end
      check("random cfg_err", int'(cfg_err), 0);
      cmp_stream("random", got_q.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
